// File: rtl/index_frame_decoder_pkg.sv
// Shared configuration for the index frame decoder: frame field positions,
// addressing and timing defaults, and the decoder state encoding.
package index_frame_decoder_pkg;

    localparam int unsigned NUM_OF_MODULES = 8;

    localparam int unsigned ID_W    = 4;
    localparam int unsigned INDEX_W = 12;

    // Byte 1 = {id, index[11:8]}, byte 2 = index[7:0]
    localparam int unsigned ID_MSB = 7;
    localparam int unsigned ID_LSB = 4;
    localparam int unsigned HI_MSB = 3;
    localparam int unsigned HI_LSB = 0;

    localparam logic [ID_W-1:0] DEF_BROADCAST_ID = 4'hF;
    localparam int unsigned     DEF_TABLE_LEN    = 3600;
    localparam int unsigned     DEF_BYTE_TIMEOUT = 2400;
    localparam int unsigned     DEF_WATCHDOG     = 240000;

    typedef enum logic [1:0] {
        S_WAIT_HI,
        S_WAIT_LO,
        S_DROP
    } state_t;

    function automatic logic id_accepted(input logic [ID_W-1:0] id,
                                         input logic [ID_W-1:0] module_id,
                                         input logic [ID_W-1:0] broadcast_id);
        return (id == module_id) || (id == broadcast_id);
    endfunction

endpackage

// File: rtl/index_frame_decoder_sat_counter.sv
// Up-counter with synchronous clear that holds at MAX instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/index_frame_decoder.sv
// Decodes two-byte {id, index} frames from a UART into a sine-table index,
// with inter-byte timeout, error counting and a drive-inhibit watchdog.
module index_frame_decoder
    import index_frame_decoder_pkg::*;
#(
    parameter logic [ID_W-1:0] MODULE_ID    = 4'h1,
    parameter logic [ID_W-1:0] BROADCAST_ID = DEF_BROADCAST_ID,
    parameter int unsigned     TABLE_LEN    = DEF_TABLE_LEN,
    parameter int unsigned     BYTE_TIMEOUT = DEF_BYTE_TIMEOUT,
    parameter int unsigned     WATCHDOG     = DEF_WATCHDOG
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_done,
    input  logic               parity_error,
    output logic [INDEX_W-1:0] sin_index,
    output logic               index_valid,
    output logic               frame_error,
    output logic [7:0]         error_count,
    output logic               inhibit
);

    localparam int unsigned TO_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int unsigned WD_W = $clog2(WATCHDOG + 1);

    localparam logic [INDEX_W:0] TABLE_LIMIT  = (INDEX_W + 1)'(TABLE_LEN);
    localparam logic [TO_W-1:0]  TIMEOUT_LIM  = TO_W'(BYTE_TIMEOUT);
    localparam logic [WD_W-1:0]  WATCHDOG_LIM = WD_W'(WATCHDOG);

    state_t             state;
    logic [ID_W-1:0]    id_q;
    logic [3:0]         hi_q;
    logic [TO_W-1:0]    to_count;
    logic [WD_W-1:0]    wd_count;
    logic               wd_armed;
    logic [INDEX_W-1:0] frame_index;
    logic               in_range;
    logic               timeout_hit;

    assign frame_index = {hi_q, rx_data};
    assign in_range    = ({1'b0, frame_index} < TABLE_LIMIT);
    assign timeout_hit = (state == S_WAIT_LO) && !rx_done && (to_count == TIMEOUT_LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_WAIT_HI;
            id_q        <= '0;
            hi_q        <= '0;
            sin_index   <= '0;
            index_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            index_valid <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                S_WAIT_HI: begin
                    // A strobe arriving while the previous index is being
                    // published is a back-to-back byte; discard it.
                    if (rx_done) begin
                        if (index_valid) begin
                            state <= S_DROP;
                        end else if (parity_error) begin
                            frame_error <= 1'b1;
                        end else begin
                            id_q  <= rx_data[ID_MSB:ID_LSB];
                            hi_q  <= rx_data[HI_MSB:HI_LSB];
                            state <= S_WAIT_LO;
                        end
                    end
                end
                S_WAIT_LO: begin
                    if (rx_done) begin
                        state <= S_WAIT_HI;
                        if (parity_error) begin
                            frame_error <= 1'b1;
                        end else if (id_accepted(id_q, MODULE_ID, BROADCAST_ID)) begin
                            if (in_range) begin
                                sin_index   <= frame_index;
                                index_valid <= 1'b1;
                            end else begin
                                frame_error <= 1'b1;
                            end
                        end
                    end else if (timeout_hit) begin
                        frame_error <= 1'b1;
                        state       <= S_WAIT_HI;
                    end
                end
                S_DROP: begin
                    state <= S_WAIT_HI;
                end
                default: begin
                    state <= S_WAIT_HI;
                end
            endcase
        end
    end

    // Output stays inhibited from reset until the first good frame arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_armed <= 1'b0;
        end else if (index_valid) begin
            wd_armed <= 1'b1;
        end
    end

    assign inhibit = !index_valid && (!wd_armed || (wd_count == WATCHDOG_LIM));

    sat_counter #(
        .WIDTH (TO_W),
        .MAX   (BYTE_TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != S_WAIT_LO),
        .enable ((state == S_WAIT_LO) && !rx_done),
        .count  (to_count)
    );

    sat_counter #(
        .WIDTH (WD_W),
        .MAX   (WATCHDOG)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (index_valid),
        .enable (1'b1),
        .count  (wd_count)
    );

    sat_counter #(
        .WIDTH (8),
        .MAX   (255)
    ) u_errors (
        .clk    (clk),
        .reset  (reset),
        .clear  (1'b0),
        .enable (frame_error),
        .count  (error_count)
    );

endmodule

// File: tb/tb_index_frame_decoder.sv
// Scoreboard bench for index_frame_decoder: every driven byte that should
// produce an index update or error queues its expected event and cycle.
module tb_index_frame_decoder;

    localparam int unsigned WD = 1000;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        parity_error;
    logic [11:0] sin_index;
    logic        index_valid;
    logic        frame_error;
    logic [7:0]  error_count;
    logic        inhibit;

    index_frame_decoder #(
        .MODULE_ID    (4'h1),
        .BROADCAST_ID (4'hF),
        .TABLE_LEN    (3600),
        .BYTE_TIMEOUT (2400),
        .WATCHDOG     (WD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .parity_error (parity_error),
        .sin_index    (sin_index),
        .index_valid  (index_valid),
        .frame_error  (frame_error),
        .error_count  (error_count),
        .inhibit      (inhibit)
    );

    typedef struct {
        int          kind;   // 1 = index update, 2 = frame error
        logic [11:0] idx;
        int          at;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [11:0] exp_sin = '0;
    int          exp_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input logic [11:0] idx, input int at);
        exp_t e;
        if (kind != 0) begin
            e.kind = kind;
            e.idx  = idx;
            e.at   = at;
            sbq.push_back(e);
            if (kind == 1) exp_sin = idx;
            if (kind == 2 && exp_err < 255) exp_err++;
        end
    endtask

    task automatic strobe(input logic [7:0] b, input logic perr, input int kind, input logic [11:0] idx);
        rx_data      = b;
        parity_error = perr;
        rx_done      = 1'b1;
        push_exp(kind, idx, cyc + 1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_done      = 1'b0;
        parity_error = 1'b0;
        rx_data      = '0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset && (index_valid || frame_error)) begin
            exp_t e;
            check_eq("excl", {31'b0, index_valid & frame_error}, 32'd0);
            check_eq("sb_pending", {31'b0, sbq.size() != 0}, 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check_eq("ev_kind", index_valid ? 32'd1 : 32'd2, e.kind);
                check_eq("ev_cycle", cyc, e.at);
                if (e.kind == 1) check_eq("ev_index", {20'b0, sin_index}, {20'b0, e.idx});
            end
        end
    end

    initial begin
        reset        = 1'b0;
        rx_data      = '0;
        rx_done      = 1'b0;
        parity_error = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_sin", {20'b0, sin_index}, 32'h0);
        check_eq("rst_valid", {31'b0, index_valid}, 32'd0);
        check_eq("rst_ferr", {31'b0, frame_error}, 32'd0);
        check_eq("rst_errcnt", {24'b0, error_count}, 32'd0);
        check_eq("rst_inhibit", {31'b0, inhibit}, 32'd1);
        reset = 1'b1;
        idle(2);
        check_eq("post_rst_inhibit", {31'b0, inhibit}, 32'd1);

        // Good frame, bytes 20 cycles apart
        strobe(8'h1A, 1'b0, 0, '0);
        idle(20);
        strobe(8'h2B, 1'b0, 1, 12'hA2B);
        idle(3);
        check_eq("sin_a2b", {20'b0, sin_index}, {20'b0, exp_sin});
        check_eq("inhibit_after_good", {31'b0, inhibit}, 32'd0);

        // Foreign id ignored, broadcast accepted
        strobe(8'h3A, 1'b0, 0, '0);
        idle(2);
        strobe(8'h2B, 1'b0, 0, '0);
        idle(3);
        check_eq("sin_foreign", {20'b0, sin_index}, {20'b0, exp_sin});
        strobe(8'hF0, 1'b0, 0, '0);
        idle(2);
        strobe(8'h05, 1'b0, 1, 12'h005);
        idle(3);

        // Inter-byte timeout, then a max in-range index (3599)
        strobe(8'h10, 1'b0, 0, '0);
        push_exp(2, '0, cyc + 2401);
        idle(2410);
        check_eq("inhibit_expired", {31'b0, inhibit}, 32'd1);
        strobe(8'h1E, 1'b0, 0, '0);
        idle(2);
        strobe(8'h0F, 1'b0, 1, 12'hE0F);
        idle(3);
        check_eq("sin_e0f", {20'b0, sin_index}, {20'b0, exp_sin});
        check_eq("inhibit_rearmed", {31'b0, inhibit}, 32'd0);
        check_eq("errcnt_timeout", {24'b0, error_count}, exp_err);

        // Parity error on low byte, then on a high byte; next byte is a high byte
        strobe(8'h1A, 1'b0, 0, '0);
        idle(2);
        strobe(8'h2B, 1'b1, 2, '0);
        idle(3);
        strobe(8'h1C, 1'b1, 2, '0);
        idle(3);
        strobe(8'h11, 1'b0, 0, '0);
        idle(2);
        strobe(8'h22, 1'b0, 1, 12'h122);
        idle(3);
        check_eq("errcnt_parity", {24'b0, error_count}, exp_err);

        // Index 3600 is out of range
        strobe(8'h1E, 1'b0, 0, '0);
        idle(2);
        strobe(8'h10, 1'b0, 2, '0);
        idle(3);
        check_eq("sin_oor_kept", {20'b0, sin_index}, {20'b0, exp_sin});

        // Back-to-back strobe right after a completed frame is dropped
        strobe(8'h1A, 1'b0, 0, '0);
        idle(3);
        strobe(8'h2B, 1'b0, 1, 12'hA2B);
        strobe(8'h1C, 1'b0, 0, '0);
        idle(3);
        strobe(8'h13, 1'b0, 0, '0);
        idle(2);
        strobe(8'h45, 1'b0, 1, 12'h345);
        idle(3);
        check_eq("sin_after_drop", {20'b0, sin_index}, {20'b0, exp_sin});

        // Reset between the two bytes discards the partial frame
        strobe(8'h1A, 1'b0, 0, '0);
        idle(5);
        reset   = 1'b0;
        exp_sin = '0;
        exp_err = 0;
        idle(2);
        check_eq("midrst_sin", {20'b0, sin_index}, {20'b0, exp_sin});
        check_eq("midrst_errcnt", {24'b0, error_count}, exp_err);
        check_eq("midrst_inhibit", {31'b0, inhibit}, 32'd1);
        reset = 1'b1;
        idle(2);
        strobe(8'h11, 1'b0, 0, '0);
        idle(4);
        strobe(8'h22, 1'b0, 1, 12'h122);
        idle(3);
        check_eq("sin_122", {20'b0, sin_index}, {20'b0, exp_sin});

        // error_count saturation
        for (int i = 0; i < 300; i++) begin
            strobe(8'(i), 1'b1, 2, '0);
            idle(1);
        end
        idle(4);
        check_eq("errcnt_sat", {24'b0, error_count}, exp_err);
        check_eq("sb_leftover", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/index_frame_decoder.md
INDEX_FRAME_DECODER -- requirements
Module: index_frame_decoder

Interface
REQ-001 Parameter MODULE_ID, default 4'h1: id this power module answers to.
REQ-002 Parameter BROADCAST_ID, default 4'hF: id accepted by every module.
REQ-003 Parameter TABLE_LEN, default 3600: number of sine-table entries; valid indices are 0..TABLE_LEN-1.
REQ-004 Parameter BYTE_TIMEOUT, default 2400: maximum clk cycles allowed between the high and low byte of one frame.
REQ-005 Parameter WATCHDOG, default 240000: clk cycles without a good frame before the output is inhibited.
REQ-006 clk  input  1  24 MHz system clock; the single clock of the block.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 rx_data  input  8  byte from uart_rx; valid only while rx_done=1.
REQ-009 rx_done  input  1  single-cycle strobe from uart_rx, one per received byte.
REQ-010 parity_error  input  1  parity flag from uart_rx, qualified by rx_done.
REQ-011 sin_index  output  12  last accepted sine-table index.
REQ-012 index_valid  output  1  one-cycle pulse when sin_index is updated.
REQ-013 frame_error  output  1  one-cycle pulse on any rejected frame.
REQ-014 error_count  output  8  saturating count of rejected frames.
REQ-015 inhibit  output  1  high when the watchdog has expired; gate drive must be blocked.

Function
REQ-016 Frame format: byte 1 = {id[3:0], index[11:8]}; byte 2 = index[7:0].
REQ-017 FSM states: WAIT_HI, WAIT_LO, DROP.
REQ-018 WAIT_HI, rx_done with parity ok: latch the id and high nibble, clear the timeout counter, go to WAIT_LO.
REQ-019 WAIT_HI, rx_done with parity_error: pulse frame_error, stay in WAIT_HI.
REQ-020 WAIT_LO: the timeout counter increments every cycle without rx_done.
REQ-021 WAIT_LO, counter reaches BYTE_TIMEOUT: pulse frame_error, go to WAIT_HI; the pending byte is discarded.
REQ-022 WAIT_LO, rx_done with parity_error: pulse frame_error, go to WAIT_HI.
REQ-023 WAIT_LO, rx_done with parity ok: assemble index = {hi_nibble, rx_data}, then apply REQ-024..026.
REQ-024 id not equal to MODULE_ID or BROADCAST_ID: frame is silently ignored (no error, no update); go to WAIT_HI.
REQ-025 id matches and index < TABLE_LEN: on the next cycle, update sin_index and pulse index_valid; go to WAIT_HI. Latency is one cycle after the second rx_done.
REQ-026 id matches and index >= TABLE_LEN: pulse frame_error, leave sin_index unchanged, go to WAIT_HI.
REQ-027 DROP: entered from WAIT_HI when rx_done arrives in the same cycle as a previous frame's completion is still being committed. DROP returns to WAIT_HI after one cycle. Because rx_done is a single-cycle strobe, DROP is only reachable through back-to-back strobes.
REQ-028 error_count increments on every frame_error pulse and saturates at 8'hFF; it never wraps.
REQ-029 Watchdog counter clears on every index_valid pulse and increments otherwise, saturating at WATCHDOG.
REQ-030 inhibit = 1 while the watchdog counter equals WATCHDOG; it drops in the same cycle that index_valid pulses.
REQ-031 index_valid and frame_error are never high in the same cycle.

Reset
REQ-032 Reset asserted: state = WAIT_HI, sin_index = 0, index_valid = 0, frame_error = 0, error_count = 0, inhibit = 1, and all counters = 0.
REQ-033 Reset asserted mid-frame discards the partial frame; the first byte after release is treated as a high byte.

Structure
REQ-034 Frame field positions, BROADCAST_ID, TABLE_LEN and the timeout defaults shall live in the shared config header, alongside NUM_OF_MODULES.
REQ-035 One sub-module, sat_counter (parameterised width, clear, enable, saturate), shall be used for the timeout counter, the watchdog counter and error_count.

Verification
REQ-036 With MODULE_ID=1, bytes 8'h1A then 8'h2B, 20 cycles apart -> sin_index=12'hA2B and index_valid pulses once, one cycle after the second strobe.
REQ-037 Bytes 8'h3A then 8'h2B -> no index_valid, no frame_error, sin_index unchanged; bytes 8'hF0 then 8'h05 -> sin_index=12'h005.
REQ-038 Byte 8'h10, then nothing for 2400 cycles, then 8'h1E, 8'h0F -> one frame_error pulse at timeout, then sin_index=12'hE0F.
REQ-039 Second byte received with parity_error=1 -> frame_error pulse, error_count=1, FSM back in WAIT_HI; index 12'hE10 (3600) -> frame_error, sin_index unchanged.
REQ-040 After reset release, inhibit=1; after a good frame inhibit=0; after WATCHDOG idle cycles inhibit=1 again.
REQ-041 Reset asserted between the two bytes, then released, then 8'h11, 8'h22 -> sin_index=12'h122; 300 bad frames -> error_count holds at 8'hFF.
